// File: rtl/mem_fault_model.sv
// rtl/mem_fault_model.sv - 256x8 SRAM model with single-fault injector (SA0/SA1/TF/CFin)
module mem_fault_model #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] iAddr,
  input  logic          iWrite,
  input  logic [DW-1:0] iWrData,
  input  logic          iRead,
  output logic [DW-1:0] oRdData,
  output logic          oRdValid,
  input  logic          FAULT_EN,
  input  logic [2:0]    FAULT_TYPE,
  input  logic [AW-1:0] FAULT_ADDR,
  input  logic [2:0]    FAULT_BIT,
  input  logic [AW-1:0] FAULT_AGG,
  output logic          oFaultAct,
  output logic [CW-1:0] oWrCnt,
  output logic [CW-1:0] oRdCnt
);

  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] FT_SA0  = 3'd1;
  localparam logic [2:0] FT_SA1  = 3'd2;
  localparam logic [2:0] FT_TFUP = 3'd3;
  localparam logic [2:0] FT_TFDN = 3'd4;
  localparam logic [2:0] FT_CFIN = 3'd5;

  logic [DW-1:0] mem [0:DEPTH-1];

  logic [DW-1:0] wr_old;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_raw;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] vic_old;
  logic          vic_hit;
  logic          cf_trig;
  logic          wr_alt;
  logic          rd_alt;

  always_comb begin
    wr_old  = mem[iAddr];
    wr_data = iWrData;
    rd_raw  = mem[iAddr];
    rd_data = rd_raw;
    vic_old = mem[FAULT_ADDR];
    vic_hit = FAULT_EN && (iAddr == FAULT_ADDR);
    cf_trig = 1'b0;

    if (vic_hit) begin
      case (FAULT_TYPE)
        FT_SA0:  wr_data[FAULT_BIT] = 1'b0;
        FT_SA1:  wr_data[FAULT_BIT] = 1'b1;
        FT_TFUP: if (!wr_old[FAULT_BIT] && iWrData[FAULT_BIT]) wr_data[FAULT_BIT] = 1'b0;
        FT_TFDN: if (wr_old[FAULT_BIT] && !iWrData[FAULT_BIT]) wr_data[FAULT_BIT] = 1'b1;
        default: wr_data = iWrData;
      endcase
      case (FAULT_TYPE)
        FT_SA0:  rd_data[FAULT_BIT] = 1'b0;
        FT_SA1:  rd_data[FAULT_BIT] = 1'b1;
        default: rd_data = rd_raw;
      endcase
    end

    // Coupling fires on a 0->1 of the aggressor bit; a self-coupled config is inert
    if (FAULT_EN && (FAULT_TYPE == FT_CFIN) && (FAULT_AGG != FAULT_ADDR) &&
        iWrite && (iAddr == FAULT_AGG) && !wr_old[FAULT_BIT] && iWrData[FAULT_BIT])
      cf_trig = 1'b1;

    wr_alt = iWrite && (wr_data != iWrData);
    rd_alt = iRead && (rd_data != rd_raw);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      oRdData   <= '0;
      oRdValid  <= 1'b0;
      oFaultAct <= 1'b0;
      oWrCnt    <= '0;
      oRdCnt    <= '0;
    end else begin
      oRdValid <= iRead;
      if (iRead) begin
        oRdData <= rd_data;
        if (oRdCnt != '1) oRdCnt <= oRdCnt + 1'b1;
      end
      if (iWrite) begin
        mem[iAddr] <= wr_data;
        if (oWrCnt != '1) oWrCnt <= oWrCnt + 1'b1;
      end
      // Aggressor and victim addresses always differ here, so no clash with the write above
      if (cf_trig) mem[FAULT_ADDR] <= vic_old ^ (DW'(1) << FAULT_BIT);
      if (wr_alt || rd_alt || cf_trig) oFaultAct <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_fault_model.sv
// tb/tb_mem_fault_model.sv - vector table and read scoreboard for mem_fault_model
module tb_mem_fault_model;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  iAddr;
  logic        iWrite;
  logic [7:0]  iWrData;
  logic        iRead;
  logic [7:0]  oRdData;
  logic        oRdValid;
  logic        FAULT_EN;
  logic [2:0]  FAULT_TYPE;
  logic [7:0]  FAULT_ADDR;
  logic [2:0]  FAULT_BIT;
  logic [7:0]  FAULT_AGG;
  logic        oFaultAct;
  logic [15:0] oWrCnt;
  logic [15:0] oRdCnt;

  always #5 CLK = ~CLK;

  mem_fault_model dut (
    .CLK(CLK), .RESET(RESET), .iAddr(iAddr), .iWrite(iWrite), .iWrData(iWrData),
    .iRead(iRead), .oRdData(oRdData), .oRdValid(oRdValid), .FAULT_EN(FAULT_EN),
    .FAULT_TYPE(FAULT_TYPE), .FAULT_ADDR(FAULT_ADDR), .FAULT_BIT(FAULT_BIT),
    .FAULT_AGG(FAULT_AGG), .oFaultAct(oFaultAct), .oWrCnt(oWrCnt), .oRdCnt(oRdCnt)
  );

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    bit         rst, w, r;
    logic [7:0] addr, wd;
    bit         fen;
    logic [2:0] ft, fb;
    logic [7:0] fa, fg, rexp;
    bit         act;
  } vec_t;
  vec_t vq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit rst, input bit w, input bit r,
                              input logic [7:0] addr, input logic [7:0] wd,
                              input bit fen, input logic [2:0] ft, input logic [2:0] fb,
                              input logic [7:0] fa, input logic [7:0] fg,
                              input logic [7:0] rexp, input bit act);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.addr = addr; v.wd = wd; v.fen = fen;
    v.ft = ft; v.fb = fb; v.fa = fa; v.fg = fg; v.rexp = rexp; v.act = act;
    vq.push_back(v);
  endfunction

  always @(negedge CLK) begin
    if (oRdValid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdvalid_unexpected actual=1 expected=0 data=%0h", oRdData);
      end else begin
        check("rddata", {24'd0, oRdData}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; iAddr = '0; iWrite = 1'b0; iWrData = '0; iRead = 1'b0;
    FAULT_EN = 1'b0; FAULT_TYPE = '0; FAULT_ADDR = '0; FAULT_BIT = '0; FAULT_AGG = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("reset_rdvalid", {31'd0, oRdValid}, 0);
    check("reset_rddata", {24'd0, oRdData}, 0);
    check("reset_faultact", {31'd0, oFaultAct}, 0);
    check("reset_wrcnt", {16'd0, oWrCnt}, 0);
    check("reset_rdcnt", {16'd0, oRdCnt}, 0);
    RESET = 1'b0;

    // Fault-free fill and readback
    for (int i = 0; i < 256; i++) begin
      iWrite = 1'b1; iAddr = 8'(i); iWrData = 8'h55;
      @(posedge CLK); #1;
    end
    iWrite = 1'b0;
    for (int i = 0; i < 256; i++) begin
      iRead = 1'b1; iAddr = 8'(i); exp_q.push_back(8'h55);
      @(posedge CLK); #1;
    end
    iRead = 1'b0;
    @(posedge CLK); #1;
    check("fill_valid_pulses", valid_seen, 256);
    check("fill_wrcnt", {16'd0, oWrCnt}, 256);
    check("fill_rdcnt", {16'd0, oRdCnt}, 256);
    check("fill_faultact", {31'd0, oFaultAct}, 0);

    // rst w r addr wd fen ft fb fa fg rexp act
    add(1,1,1,8'h10,8'hFF,0,3'd0,3'd0,8'h00,8'h00,8'h00,0);
    add(0,1,0,8'h10,8'hFF,0,3'd1,3'd0,8'h10,8'h00,8'h00,0);
    add(0,0,1,8'h10,8'h00,0,3'd1,3'd0,8'h10,8'h00,8'hFF,0);
    add(0,1,0,8'h11,8'hFF,1,3'd1,3'd0,8'h10,8'h00,8'h00,0);
    add(0,1,0,8'h10,8'hFF,1,3'd1,3'd0,8'h10,8'h00,8'h00,1);
    add(0,0,1,8'h10,8'h00,1,3'd1,3'd0,8'h10,8'h00,8'hFE,1);
    add(0,0,1,8'h11,8'h00,1,3'd1,3'd0,8'h10,8'h00,8'hFF,1);
    add(1,0,0,8'h00,8'h00,0,3'd0,3'd0,8'h00,8'h00,8'h00,0);
    add(0,1,0,8'h20,8'h00,1,3'd3,3'd7,8'h20,8'h00,8'h00,0);
    add(0,1,0,8'h20,8'h80,1,3'd3,3'd7,8'h20,8'h00,8'h00,1);
    add(0,0,1,8'h20,8'h00,1,3'd3,3'd7,8'h20,8'h00,8'h00,1);
    add(1,0,0,8'h00,8'h00,0,3'd0,3'd0,8'h00,8'h00,8'h00,0);
    add(0,1,0,8'h20,8'hFF,1,3'd4,3'd7,8'h20,8'h00,8'h00,0);
    add(0,1,0,8'h20,8'h7F,1,3'd4,3'd7,8'h20,8'h00,8'h00,1);
    add(0,0,1,8'h20,8'h00,1,3'd4,3'd7,8'h20,8'h00,8'hFF,1);
    add(1,0,0,8'h00,8'h00,0,3'd0,3'd0,8'h00,8'h00,8'h00,0);
    add(0,0,1,8'h31,8'h00,1,3'd5,3'd3,8'h31,8'h30,8'h00,0);
    add(0,1,0,8'h31,8'h00,1,3'd5,3'd3,8'h31,8'h30,8'h00,0);
    add(0,1,0,8'h30,8'h08,1,3'd5,3'd3,8'h31,8'h30,8'h00,1);
    add(0,0,1,8'h31,8'h00,1,3'd5,3'd3,8'h31,8'h30,8'h08,1);
    add(0,1,0,8'h30,8'h08,1,3'd5,3'd3,8'h31,8'h30,8'h00,1);
    add(0,0,1,8'h31,8'h00,1,3'd5,3'd3,8'h31,8'h30,8'h08,1);
    add(0,0,1,8'h30,8'h00,1,3'd5,3'd3,8'h31,8'h30,8'h08,1);
    add(1,0,0,8'h00,8'h00,0,3'd0,3'd0,8'h00,8'h00,8'h00,0);
    add(0,1,0,8'h31,8'h08,1,3'd5,3'd3,8'h31,8'h31,8'h00,0);
    add(0,0,1,8'h31,8'h00,1,3'd5,3'd3,8'h31,8'h31,8'h08,0);
    add(1,0,0,8'h00,8'h00,0,3'd0,3'd0,8'h00,8'h00,8'h00,0);
    add(0,1,0,8'h40,8'hAA,0,3'd0,3'd0,8'h00,8'h00,8'h00,0);
    add(0,1,1,8'h40,8'h33,0,3'd0,3'd0,8'h00,8'h00,8'hAA,0);
    add(0,0,1,8'h40,8'h00,0,3'd0,3'd0,8'h00,8'h00,8'h33,0);
    add(0,0,1,8'h50,8'h00,1,3'd2,3'd2,8'h50,8'h00,8'h04,1);
    add(1,0,0,8'h00,8'h00,0,3'd0,3'd0,8'h00,8'h00,8'h00,0);
    add(0,1,0,8'h60,8'hFF,1,3'd6,3'd0,8'h60,8'h00,8'h00,0);
    add(0,0,1,8'h60,8'h00,1,3'd6,3'd0,8'h60,8'h00,8'hFF,0);

    for (int n = 0; n < vq.size(); n++) begin
      RESET = vq[n].rst; iWrite = vq[n].w; iRead = vq[n].r;
      iAddr = vq[n].addr; iWrData = vq[n].wd;
      FAULT_EN = vq[n].fen; FAULT_TYPE = vq[n].ft; FAULT_BIT = vq[n].fb;
      FAULT_ADDR = vq[n].fa; FAULT_AGG = vq[n].fg;
      if (vq[n].r && !vq[n].rst) exp_q.push_back(vq[n].rexp);
      @(posedge CLK); #1;
      check($sformatf("vec%0d_faultact", n), {31'd0, oFaultAct}, {31'd0, vq[n].act});
      if (vq[n].rst) begin
        check($sformatf("vec%0d_rst_rdvalid", n), {31'd0, oRdValid}, 0);
        check($sformatf("vec%0d_rst_wrcnt", n), {16'd0, oWrCnt}, 0);
        check($sformatf("vec%0d_rst_rdcnt", n), {16'd0, oRdCnt}, 0);
      end
    end
    RESET = 1'b0; iWrite = 1'b0; iRead = 1'b0; FAULT_EN = 1'b0;
    @(posedge CLK); #1;

    // Read issued, then reset with a fresh read strobe on the next edge
    iWrite = 1'b1; iAddr = 8'h70; iWrData = 8'hC3;
    @(posedge CLK); #1;
    iWrite = 1'b0; iRead = 1'b1; exp_q.push_back(8'hC3);
    @(posedge CLK); #1;
    RESET = 1'b1; iRead = 1'b1; iWrite = 1'b1; iWrData = 8'h99;
    @(posedge CLK); #1;
    check("inflight_rdvalid", {31'd0, oRdValid}, 0);
    check("inflight_rddata", {24'd0, oRdData}, 0);
    check("inflight_wrcnt", {16'd0, oWrCnt}, 0);
    check("inflight_rdcnt", {16'd0, oRdCnt}, 0);
    RESET = 1'b0; iWrite = 1'b0; iRead = 1'b1; iAddr = 8'h70; exp_q.push_back(8'h00);
    @(posedge CLK); #1;
    iRead = 1'b0;
    check("post_reset_rdcnt", {16'd0, oRdCnt}, 1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pending_reads", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
